// File: rtl/byte_striping_nlane_pkg.sv
// Shared defaults and width helpers for the N-lane byte striper and its pointer sub-block.
package byte_striping_nlane_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_NUM_LANES = 4;

  // Pointer width for a lane count; a single-lane build still gets a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/byte_striping_nlane_if.sv
// Word-stream input and striped-lane output bundle of the N-lane byte striper.
interface byte_striping_nlane_if #(
  parameter int unsigned DATA_W    = byte_striping_nlane_pkg::DEF_DATA_W,
  parameter int unsigned NUM_LANES = byte_striping_nlane_pkg::DEF_NUM_LANES
);
  import byte_striping_nlane_pkg::*;

  localparam int unsigned PTR_W = ptr_width(NUM_LANES);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                          valid_in;
  logic [DATA_W-1:0]             data_in;
  logic [CNT_W-1:0]              active_lanes;
  logic                          flush;
  logic [NUM_LANES*DATA_W-1:0]   lane_data;
  logic [NUM_LANES-1:0]          lane_valid;
  logic [PTR_W-1:0]              lane_sel;
  logic                          frame_done;
  logic                          cfg_err;

  modport master (
    output valid_in, data_in, active_lanes, flush,
    input  lane_data, lane_valid, lane_sel, frame_done, cfg_err
  );

  modport slave (
    input  valid_in, data_in, active_lanes, flush,
    output lane_data, lane_valid, lane_sel, frame_done, cfg_err
  );

endinterface

// File: rtl/byte_striping_nlane_rr_lane_pointer.sv
// Round-robin lane pointer: owns the pointer, the latched active lane count,
// the group-boundary config latch, flush and the sticky config error.
module rr_lane_pointer
  import byte_striping_nlane_pkg::*;
#(
  parameter  int unsigned NUM_LANES = DEF_NUM_LANES,
  localparam int unsigned PTR_W     = ptr_width(NUM_LANES),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [CNT_W-1:0] active_lanes_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic             last_lane_c_o,
  output logic             cfg_err_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] act_eff_c;
  logic             cfg_err_q, cfg_err_d;
  logic             at_start_c;
  logic             cfg_ok_c;
  logic             last_c;

  // A new lane count takes effect for the group that starts on this edge.
  always_comb begin
    act_d      = act_q;
    act_eff_c  = act_q;
    cfg_err_d  = cfg_err_q;
    at_start_c = (ptr_q == '0);
    cfg_ok_c   = (active_lanes_i != '0) && (active_lanes_i <= CNT_W'(NUM_LANES));

    if (at_start_c) begin
      if (cfg_ok_c) begin
        act_d     = active_lanes_i;
        act_eff_c = active_lanes_i;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    last_c = ({1'b0, ptr_q} == (act_eff_c - CNT_W'(1)));

    ptr_d = ptr_q;
    if (valid_i) begin
      ptr_d = last_c ? '0 : (ptr_q + PTR_W'(1));
    end
    if (flush_i) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      act_q     <= CNT_W'(NUM_LANES);
      cfg_err_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      act_q     <= act_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign ptr_o         = ptr_q;
  assign last_lane_c_o = last_c;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: rtl/byte_striping_nlane.sv
// N-lane byte striper: deals a valid-qualified word stream round-robin over
// the active lanes with one cycle of latency; unwritten lanes hold their value.
module byte_striping_nlane
  import byte_striping_nlane_pkg::*;
#(
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned NUM_LANES = DEF_NUM_LANES,
  localparam int unsigned PTR_W     = ptr_width(NUM_LANES)
) (
  input  logic                clk_2f,
  input  logic                reset,
  byte_striping_nlane_if.slave bus
);

  logic [PTR_W-1:0]            ptr;
  logic                        last_c;
  logic [NUM_LANES-1:0]        lane_valid_d, lane_valid_q;
  logic                        frame_done_d, frame_done_q;
  logic [NUM_LANES*DATA_W-1:0] lane_data_flat;

  rr_lane_pointer #(
    .NUM_LANES (NUM_LANES)
  ) u_ptr (
    .clk_i          (clk_2f),
    .rst_i          (reset),
    .valid_i        (bus.valid_in),
    .flush_i        (bus.flush),
    .active_lanes_i (bus.active_lanes),
    .ptr_o          (ptr),
    .last_lane_c_o  (last_c),
    .cfg_err_o      (bus.cfg_err)
  );

  // One holding register per lane, written only when the pointer selects it.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_c;

    always_comb begin
      wr_c   = bus.valid_in && (ptr == PTR_W'(i));
      data_d = data_q;
      if (wr_c) begin
        data_d = bus.data_in;
      end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign lane_data_flat[i*DATA_W +: DATA_W] = data_q;
    assign lane_valid_d[i]                    = wr_c;
  end

  always_comb begin
    frame_done_d = bus.valid_in && last_c;
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      lane_valid_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      lane_valid_q <= lane_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.lane_data  = lane_data_flat;
  assign bus.lane_valid = lane_valid_q;
  assign bus.lane_sel   = ptr;
  assign bus.frame_done = frame_done_q;

endmodule
